// File: rtl/vmult_lane_sequencer.sv
// Time-multiplexes one combinational fp16 multiplier across a LANES-wide vector.
// Enabled lanes are issued lowest-first, one per cycle; disabled lanes are skipped at no cost.
module vmult_lane_sequencer #(
  parameter int LANES = 4,
  parameter int DW    = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [LANES*DW-1:0] vec_a,
  input  logic [LANES*DW-1:0] vec_b,
  input  logic [LANES-1:0]    lane_en,
  output logic                busy,
  output logic                done,
  output logic [LANES*DW-1:0] result,
  output logic                overflow,
  output logic [LANES-1:0]    overflow_mask,
  output logic [DW-1:0]       mul_a,
  output logic [DW-1:0]       mul_b,
  input  logic [DW-1:0]       mul_product,
  input  logic                mul_overflow
);

  localparam int IW = (LANES > 1) ? $clog2(LANES) : 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t              state_reg, state_next;
  logic [LANES*DW-1:0] a_reg, a_next;
  logic [LANES*DW-1:0] b_reg, b_next;
  logic [LANES-1:0]    en_reg, en_next;
  logic [IW-1:0]       cur_reg, cur_next;
  logic [LANES*DW-1:0] result_reg, result_next;
  logic [LANES-1:0]    mask_reg, mask_next;
  logic                ovf_reg, ovf_next;
  logic                busy_reg, busy_next;
  logic                done_reg, done_next;
  logic [DW-1:0]       mul_a_reg, mul_a_next;
  logic [DW-1:0]       mul_b_reg, mul_b_next;

  logic [DW-1:0] a_lane  [LANES];
  logic [DW-1:0] b_lane  [LANES];
  logic [DW-1:0] va_lane [LANES];
  logic [DW-1:0] vb_lane [LANES];

  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      assign a_lane[gi]  = a_reg[gi*DW +: DW];
      assign b_lane[gi]  = b_reg[gi*DW +: DW];
      assign va_lane[gi] = vec_a[gi*DW +: DW];
      assign vb_lane[gi] = vec_b[gi*DW +: DW];
    end
  endgenerate

  // Priority searches: lowest enabled lane of the incoming request, and the
  // next enabled lane strictly above the one currently in the multiplier.
  logic [IW-1:0] first_idx;
  logic [IW-1:0] next_idx;
  logic          next_found;

  always_comb begin
    first_idx = '0;
    for (int k = LANES - 1; k >= 0; k--) begin
      if (lane_en[k]) first_idx = IW'(k);
    end
  end

  always_comb begin
    next_found = 1'b0;
    next_idx   = cur_reg;
    for (int k = LANES - 1; k >= 0; k--) begin
      if (en_reg[k] && (k > int'(cur_reg))) begin
        next_found = 1'b1;
        next_idx   = IW'(k);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      a_reg      <= '0;
      b_reg      <= '0;
      en_reg     <= '0;
      cur_reg    <= '0;
      result_reg <= '0;
      mask_reg   <= '0;
      ovf_reg    <= 1'b0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
      mul_a_reg  <= '0;
      mul_b_reg  <= '0;
    end else begin
      state_reg  <= state_next;
      a_reg      <= a_next;
      b_reg      <= b_next;
      en_reg     <= en_next;
      cur_reg    <= cur_next;
      result_reg <= result_next;
      mask_reg   <= mask_next;
      ovf_reg    <= ovf_next;
      busy_reg   <= busy_next;
      done_reg   <= done_next;
      mul_a_reg  <= mul_a_next;
      mul_b_reg  <= mul_b_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start && (lane_en != '0)) state_next = RUN;
      RUN:     if (!next_found) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    a_next      = a_reg;
    b_next      = b_reg;
    en_next     = en_reg;
    cur_next    = cur_reg;
    result_next = result_reg;
    mask_next   = mask_reg;
    ovf_next    = ovf_reg;
    busy_next   = busy_reg;
    done_next   = 1'b0;
    mul_a_next  = mul_a_reg;
    mul_b_next  = mul_b_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          a_next    = vec_a;
          b_next    = vec_b;
          en_next   = lane_en;
          mask_next = '0;
          ovf_next  = 1'b0;
          for (int k = 0; k < LANES; k++) begin
            if (!lane_en[k]) result_next[k*DW +: DW] = '0;
          end
          if (lane_en != '0) begin
            cur_next   = first_idx;
            mul_a_next = va_lane[first_idx];
            mul_b_next = vb_lane[first_idx];
            busy_next  = 1'b1;
          end else begin
            done_next = 1'b1;
          end
        end
      end
      RUN: begin
        result_next[int'(cur_reg)*DW +: DW] = mul_product;
        mask_next[cur_reg] = mul_overflow;
        ovf_next = ovf_reg | mul_overflow;
        if (next_found) begin
          cur_next   = next_idx;
          mul_a_next = a_lane[next_idx];
          mul_b_next = b_lane[next_idx];
        end else begin
          done_next  = 1'b1;
          busy_next  = 1'b0;
          mul_a_next = '0;
          mul_b_next = '0;
        end
      end
      default: ;
    endcase
  end

  assign busy          = busy_reg;
  assign done          = done_reg;
  assign result        = result_reg;
  assign overflow      = ovf_reg;
  assign overflow_mask = mask_reg;
  assign mul_a         = mul_a_reg;
  assign mul_b         = mul_b_reg;

endmodule

// File: tb/tb_vmult_lane_sequencer.sv
// Bench for vmult_lane_sequencer: a behavioural fp16 multiplier stub and an
// expected-vector model built from the lane enables, plus directed corner cases.
module tb_vmult_lane_sequencer;
  localparam int LANES = 4;
  localparam int DW    = 16;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                start = 1'b0;
  logic [LANES*DW-1:0] vec_a = '0;
  logic [LANES*DW-1:0] vec_b = '0;
  logic [LANES-1:0]    lane_en = '0;
  logic                busy, done, overflow, mul_overflow;
  logic [LANES*DW-1:0] result;
  logic [LANES-1:0]    overflow_mask;
  logic [DW-1:0]       mul_a, mul_b, mul_product;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  vmult_lane_sequencer #(.LANES(LANES), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .vec_a(vec_a), .vec_b(vec_b),
    .lane_en(lane_en), .busy(busy), .done(done), .result(result),
    .overflow(overflow), .overflow_mask(overflow_mask), .mul_a(mul_a),
    .mul_b(mul_b), .mul_product(mul_product), .mul_overflow(mul_overflow)
  );

  // Truncating fp16 multiply for normal operands; zero/denormal inputs flush to zero.
  function automatic logic [16:0] fp16_mul(input logic [15:0] x, input logic [15:0] y);
    logic        s;
    int          e;
    logic [21:0] p;
    logic [9:0]  m;
    s = x[15] ^ y[15];
    if (x[14:10] == 5'd0 || y[14:10] == 5'd0) return {1'b0, s, 15'h0};
    p = {1'b1, x[9:0]} * {1'b1, y[9:0]};
    e = int'(x[14:10]) + int'(y[14:10]) - 15;
    if (p[21]) begin
      m = p[20:11];
      e++;
    end else begin
      m = p[19:10];
    end
    if (e >= 31) return {1'b1, s, 15'h7C00};
    if (e <= 0) return {1'b0, s, 15'h0};
    return {1'b0, s, e[4:0], m};
  endfunction

  assign {mul_overflow, mul_product} = fp16_mul(mul_a, mul_b);

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [LANES*DW-1:0] rand_vec();
    logic [LANES*DW-1:0] v;
    for (int k = 0; k < LANES; k++)
      v[k*DW +: DW] = {1'($urandom), 5'($urandom_range(1, 30)), 10'($urandom)};
    return v;
  endfunction

  task automatic drive_start(input logic [63:0] a, input logic [63:0] b, input logic [3:0] en);
    vec_a   = a;
    vec_b   = b;
    lane_en = en;
    start   = 1'b1;
  endtask

  task automatic scramble();
    vec_a   = {$urandom, $urandom};
    vec_b   = {$urandom, $urandom};
    lane_en = 4'($urandom);
  endtask

  // Called #1 after E0. mode 1 pokes a stray start mid-op, then holds start
  // high with the a2/b2/en2 request so it is taken on the done cycle.
  task automatic track_op(input logic [63:0] a, input logic [63:0] b, input logic [3:0] en,
                          input int mode, input logic [63:0] a2, input logic [63:0] b2,
                          input logic [3:0] en2);
    int seq[$];
    logic [63:0] exp_res;
    logic [3:0]  exp_mask;
    logic [16:0] pr;
    int cyc, idx, busy_cnt;
    exp_res  = '0;
    exp_mask = '0;
    for (int k = 0; k < LANES; k++) begin
      if (en[k]) begin
        seq.push_back(k);
        pr = fp16_mul(a[k*DW +: DW], b[k*DW +: DW]);
        exp_res[k*DW +: DW] = pr[15:0];
        exp_mask[k] = pr[16];
      end
    end
    start = 1'b0;
    scramble();
    cyc = 0;
    idx = 0;
    busy_cnt = 0;
    while (!done && cyc < 40) begin
      if (busy) begin
        busy_cnt++;
        if (idx < seq.size())
          check("mul_operands", {32'h0, mul_a, mul_b},
                {32'h0, a[seq[idx]*DW +: DW], b[seq[idx]*DW +: DW]});
        else
          check("busy_overrun", 64'(busy), 64'd0);
        idx++;
      end
      if (mode == 1 && cyc == 1) drive_start(rand_vec(), rand_vec(), 4'hF);
      if (mode == 1 && cyc == 2) begin
        start = 1'b0;
        scramble();
      end
      if (mode == 1 && cyc == 3) drive_start(a2, b2, en2);
      @(posedge clk);
      #1;
      cyc++;
    end
    check("done_seen", 64'(done), 64'd1);
    check("latency", 64'(cyc), 64'(seq.size()));
    check("busy_cycles", 64'(busy_cnt), 64'(seq.size()));
    check("busy_at_done", 64'(busy), 64'd0);
    check("mul_idle", {32'h0, mul_a, mul_b}, 64'd0);
    check("result", result, exp_res);
    check("overflow_mask", 64'(overflow_mask), 64'(exp_mask));
    check("overflow", 64'(overflow), 64'(|exp_mask));
    $display("op en=%b n=%0d cycles=%0d result=%h ovf=%b mask=%b",
             en, seq.size(), cyc, result, overflow, overflow_mask);
  endtask

  task automatic run_op(input logic [63:0] a, input logic [63:0] b, input logic [3:0] en);
    logic [63:0] held;
    @(negedge clk);
    drive_start(a, b, en);
    @(posedge clk);
    #1;
    track_op(a, b, en, 0, '0, '0, '0);
    held = result;
    @(posedge clk);
    #1;
    check("done_single", 64'(done), 64'd0);
    check("result_hold", result, held);
  endtask

  logic [63:0] ta, tb_v, a2, b2;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_outputs", {busy, done, overflow, overflow_mask, mul_a, mul_b}, 64'd0);
    check("rst_result", result, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed vectors: lanes listed high..low in the concatenation.
    ta   = {16'hBC00, 16'h3E00, 16'h4000, 16'h3C00};
    tb_v = {16'h3C00, 16'h4000, 16'h4000, 16'h4000};
    run_op(ta, tb_v, 4'hF);
    check("t1_const", result, {16'hBC00, 16'h4200, 16'h4400, 16'h4000});
    run_op(ta, tb_v, 4'b1010);
    check("t2_const", result, {16'hBC00, 16'h0000, 16'h4400, 16'h0000});
    run_op(ta, tb_v, 4'b0000);
    check("t3_zero", result, 64'd0);
    run_op({16'h3C00, 16'h7BFF, 16'h3C00, 16'h3C00}, {16'h3C00, 16'h7BFF, 16'h3C00, 16'h3C00}, 4'hF);
    check("t4_mask", 64'(overflow_mask), 64'h4);
    check("t4_lane2", 64'(result[47:32]), 64'h7C00);
    run_op(ta, tb_v, 4'hF);
    check("t4_cleared", 64'({overflow, overflow_mask}), 64'd0);

    // Stray start while busy, then a request held high into the done cycle.
    a2 = rand_vec();
    b2 = rand_vec();
    @(negedge clk);
    drive_start(ta, tb_v, 4'hF);
    @(posedge clk);
    #1;
    track_op(ta, tb_v, 4'hF, 1, a2, b2, 4'b0110);
    check("b2b_start_held", 64'(start), 64'd1);
    @(posedge clk);
    #1;
    check("b2b_done_drop", 64'(done), 64'd0);
    track_op(a2, b2, 4'b0110, 0, '0, '0, '0);
    @(posedge clk);
    #1;
    check("b2b_done_single", 64'(done), 64'd0);

    // Asynchronous reset while lane 1 is in the multiplier.
    @(negedge clk);
    drive_start(ta, tb_v, 4'hF);
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    #1;
    check("rst_mid_lane1", 64'(mul_a), 64'h4000);
    #1;
    rst_n = 1'b0;
    #1;
    check("rst_async_outputs", {busy, done, overflow, overflow_mask, mul_a, mul_b}, 64'd0);
    check("rst_async_result", result, 64'd0);
    @(posedge clk);
    #1;
    check("rst_hold", 64'({busy, done}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) begin
      @(posedge clk);
      #1;
      check("no_done_after_rst", 64'({busy, done}), 64'd0);
    end
    run_op(ta, tb_v, 4'hF);

    for (int t = 0; t < 24; t++) run_op(rand_vec(), rand_vec(), 4'($urandom));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
